// File: rtl/plot_pixel_sink.sv
// plot_pixel_sink
//   Receiving end of the (x, y, colour) plot interface. Pixel-write requests
//   arrive over a valid/ready handshake, are buffered in a DEPTH-entry FIFO,
//   and are drained to the VGA adapter write port, at most one pixel per cycle.
//
// Ports
//   clk, resetn            clock (posedge) and synchronous active-low reset
//   in_valid / in_ready    producer handshake; transfer when both high at posedge
//   in_x, in_y, in_colour  request pixel (8 / 7 / 3 bits)
//   drain_en               permits adapter writes; 0 stalls the output side
//   vga_x, vga_y,
//   vga_colour, vga_plot   registered adapter write port
//   level                  current FIFO occupancy (0..DEPTH)
//
// Configuration
//   PLOT_BOX_EXPAND_EN     when defined, every FIFO entry is expanded into a
//                          BOX_W x BOX_H box (row-major, coordinates wrap).
module plot_pixel_sink #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned BOX_W = 4,
  parameter int unsigned BOX_H = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_x,
  input  logic [6:0]               in_y,
  input  logic [2:0]               in_colour,
  input  logic                     drain_en,
  output logic [7:0]               vga_x,
  output logic [6:0]               vga_y,
  output logic [2:0]               vga_colour,
  output logic                     vga_plot,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

  // FIFO storage and pointers
  logic [17:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q, level_d;

  logic          full, empty, push, pop;
  logic [7:0]    head_x;
  logic [6:0]    head_y;
  logic [2:0]    head_c;

  state_e        state_q, state_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [2:0]    c_q, c_d;
  logic          plot_q, plot_d;

`ifdef PLOT_BOX_EXPAND_EN
  localparam logic [2:0] LAST_DX = 3'(BOX_W - 1);
  localparam logic [2:0] LAST_DY = 3'(BOX_H - 1);

  logic [7:0] base_x_q, base_x_d;
  logic [6:0] base_y_q, base_y_d;
  logic [2:0] base_c_q, base_c_d;
  logic [2:0] dx_q, dx_d, dy_q, dy_d;
`endif

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  // Derived from registered occupancy only; forced low while reset is asserted.
  assign in_ready = resetn && !full;
  assign push     = in_valid && in_ready;

  assign {head_x, head_y, head_c} = mem_q[rd_q];

  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = c_q;
  assign vga_plot   = plot_q;
  assign level      = level_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    plot_d  = 1'b0;
`ifdef PLOT_BOX_EXPAND_EN
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    base_c_d = base_c_q;
    dx_d     = dx_q;
    dy_d     = dy_q;

    // dx/dy always index the next box pixel still to be emitted. The pop in
    // IDLE emits pixel (0,0) straight from the FIFO head so box mode keeps the
    // same first-pixel latency as single-pixel mode.
    case (state_q)
      IDLE: begin
        if (drain_en && !empty) begin
          pop      = 1'b1;
          x_d      = head_x;
          y_d      = head_y;
          c_d      = head_c;
          plot_d   = 1'b1;
          base_x_d = head_x;
          base_y_d = head_y;
          base_c_d = head_c;
          if (LAST_DX == 3'd0 && LAST_DY == 3'd0) begin
            state_d = IDLE;
          end else begin
            state_d = DRAW;
            if (LAST_DX == 3'd0) begin
              dx_d = 3'd0;
              dy_d = 3'd1;
            end else begin
              dx_d = 3'd1;
              dy_d = 3'd0;
            end
          end
        end
      end
      DRAW: begin
        if (drain_en) begin
          x_d    = base_x_q + {5'b0, dx_q};
          y_d    = base_y_q + {4'b0, dy_q};
          c_d    = base_c_q;
          plot_d = 1'b1;
          if (dx_q == LAST_DX && dy_q == LAST_DY) begin
            dx_d = 3'd0;
            dy_d = 3'd0;
            // Chain straight into the next box: its (0,0) comes from base
            // on the following cycle, so there is no bubble.
            if (!empty) begin
              pop      = 1'b1;
              base_x_d = head_x;
              base_y_d = head_y;
              base_c_d = head_c;
            end else begin
              state_d = IDLE;
            end
          end else if (dx_q == LAST_DX) begin
            dx_d = 3'd0;
            dy_d = dy_q + 3'd1;
          end else begin
            dx_d = dx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`else
    state_d = IDLE;
    if (drain_en && !empty) begin
      pop    = 1'b1;
      x_d    = head_x;
      y_d    = head_y;
      c_d    = head_c;
      plot_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= {in_x, in_y, in_colour};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      plot_q  <= 1'b0;
`ifdef PLOT_BOX_EXPAND_EN
      base_x_q <= '0;
      base_y_q <= '0;
      base_c_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
`endif
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      level_q <= level_d;
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      plot_q  <= plot_d;
`ifdef PLOT_BOX_EXPAND_EN
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      base_c_q <= base_c_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
`endif
    end
  end

endmodule

// File: tb/tb_plot_pixel_sink.sv
// Directed testbench for plot_pixel_sink (DEPTH=16, 4x4 box when
// PLOT_BOX_EXPAND_EN is defined).
module tb_plot_pixel_sink;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       drain_en;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [4:0] level;

  int checks   = 0;
  int failures = 0;

  plot_pixel_sink #(.DEPTH(16), .BOX_W(4), .BOX_H(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_colour (in_colour),
    .drain_en  (drain_en),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    in_valid  = v;
    in_x      = x;
    in_y      = y;
    in_colour = c;
  endtask

  initial begin
    resetn   = 1'b0;
    drain_en = 1'b0;
    drive(1'b0, 8'd0, 7'd0, 3'd0);

    // Reset
    tick();
    check("rst_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_vga", {13'd0, vga_x, vga_y, vga_colour, vga_plot}, 32'd0);
    resetn = 1'b1;
    #1;
    check("rst_ready_after", 32'(in_ready), 32'd1);

`ifdef PLOT_BOX_EXPAND_EN
    // 4x4 box at (158,118) colour 2; x wraps past screen edge unchanged
    drain_en = 1'b1;
    drive(1'b1, 8'd158, 7'd118, 3'd2);
    tick();
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    check("box_push_plot", 32'(vga_plot), 32'd0);
    for (int p = 0; p < 16; p++) begin
      tick();
      check("box_plot", 32'(vga_plot), 32'd1);
      check("box_x", 32'(vga_x), 32'(158 + (p % 4)));
      check("box_y", 32'(vga_y), 32'(118 + (p / 4)));
      check("box_c", 32'(vga_colour), 32'd2);
    end
    tick();
    check("box_idle_plot", 32'(vga_plot), 32'd0);

    // Reset after 5 of 16 pixels, with a second box queued
    drive(1'b1, 8'd10, 7'd20, 3'd5);
    tick();
    drive(1'b1, 8'd30, 7'd40, 3'd1);
    tick();
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    check("mid_first_x", 32'(vga_x), 32'd10);
    check("mid_level", 32'(level), 32'd1);
    for (int p = 1; p < 5; p++) tick();
    check("mid_5th_x", 32'(vga_x), 32'd10);
    check("mid_5th_y", 32'(vga_y), 32'd21);
    check("mid_5th_plot", 32'(vga_plot), 32'd1);
    resetn = 1'b0;
    tick();
    check("mid_rst_plot", 32'(vga_plot), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    resetn = 1'b1;
    for (int p = 0; p < 3; p++) begin
      tick();
      check("mid_after_plot", 32'(vga_plot), 32'd0);
    end
`else
    // Single pixel latency
    drain_en = 1'b1;
    drive(1'b1, 8'd38, 7'd4, 3'b100);
    tick();
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    check("single_edgeN_plot", 32'(vga_plot), 32'd0);
    check("single_edgeN_level", 32'(level), 32'd1);
    tick();
    check("single_plot", 32'(vga_plot), 32'd1);
    check("single_x", 32'(vga_x), 32'd38);
    check("single_y", 32'(vga_y), 32'd4);
    check("single_c", 32'(vga_colour), 32'd4);
    check("single_level", 32'(level), 32'd0);
    tick();
    check("single_after_plot", 32'(vga_plot), 32'd0);
    check("single_hold_x", 32'(vga_x), 32'd38);

    // Fill to DEPTH with drain stalled, then a 17th held by the producer
    drain_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(10 + i), 7'(i), 3'(i));
      check("fill_ready", 32'(in_ready), 32'd1);
      tick();
    end
    check("full_level", 32'(level), 32'd16);
    check("full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 8'd200, 7'd100, 3'd7);
    tick();
    check("full_hold_level", 32'(level), 32'd16);
    check("full_stall_plot", 32'(vga_plot), 32'd0);
    check("full_stall_hold_x", 32'(vga_x), 32'd38);

    // Drain: 16 in order, the 17th enters at the second drain edge
    drain_en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      if (k == 1) drive(1'b0, 8'd0, 7'd0, 3'd0);
      check("drain_plot", 32'(vga_plot), 32'd1);
      check("drain_x", 32'(vga_x), (k < 16) ? 32'(10 + k) : 32'd200);
      check("drain_y", 32'(vga_y), (k < 16) ? 32'(k) : 32'd100);
      check("drain_level", 32'(level), (k == 0) ? 32'd15 : 32'(16 - k));
    end
    tick();
    check("drain_done_plot", 32'(vga_plot), 32'd0);

    // Stall in the middle of a burst of 4
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(50 + i), 7'(60 + i), 3'(i + 1));
      tick();
    end
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    check("stall_level", 32'(level), 32'd4);
    drain_en = 1'b1;
    tick();
    check("stall_p0_plot", 32'(vga_plot), 32'd1);
    check("stall_p0_x", 32'(vga_x), 32'd50);
    drain_en = 1'b0;
    tick();
    check("stall_gap_plot", 32'(vga_plot), 32'd0);
    check("stall_gap_x", 32'(vga_x), 32'd50);
    check("stall_gap_level", 32'(level), 32'd3);
    drain_en = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("stall_plot", 32'(vga_plot), 32'd1);
      check("stall_x", 32'(vga_x), 32'(50 + i));
      check("stall_c", 32'(vga_colour), 32'(i + 1));
    end
    tick();
    check("stall_end_plot", 32'(vga_plot), 32'd0);
    check("stall_end_level", 32'(level), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
